// File: rtl/button_debouncer.sv
// button_debouncer: synchronises a raw button level and qualifies each transition
// over a programmable window before changing the registered debounced output.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic n_rst,
    input  logic btn_raw,
    output logic db_out,
    output logic busy,
    output logic glitch
);
    // bit 1 is the debounced level, bit 0 marks a wait state
    localparam logic [1:0] S_LOW       = 2'd0;
    localparam logic [1:0] S_WAIT_HIGH = 2'd1;
    localparam logic [1:0] S_HIGH      = 2'd2;
    localparam logic [1:0] S_WAIT_LOW  = 2'd3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic             sync1_q, s_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, busy_q, glitch_q, glitch_d;
    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        glitch_d = 1'b0;
        case (state_q)
            S_LOW:  state_d = s_q ? S_WAIT_HIGH : S_LOW;
            S_HIGH: state_d = s_q ? S_HIGH : S_WAIT_LOW;
            S_WAIT_HIGH: begin
                if (!s_q) begin
                    state_d  = S_LOW;
                    glitch_d = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HIGH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_LOW: begin
                if (s_q) begin
                    state_d  = S_HIGH;
                    glitch_d = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LOW;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_LOW;
        endcase
    end
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1_q  <= 1'b0;
            s_q      <= 1'b0;
            state_q  <= S_LOW;
            cnt_q    <= '0;
            db_q     <= 1'b0;
            busy_q   <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            sync1_q  <= btn_raw;
            s_q      <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            db_q     <= state_d[1];
            busy_q   <= state_d[0];
            glitch_q <= glitch_d;
        end
    end
    assign db_out = db_q;
    assign busy   = busy_q;
    assign glitch = glitch_q;
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed scenarios against a run-length reference model,
// with per-cycle expectations queued at each edge and compared mid-cycle.
module tb_button_debouncer;
    localparam int D = 8;
    logic clk = 1'b0;
    logic n_rst;
    logic btn_raw;
    logic db_out, busy, glitch;
    int checks = 0, errors = 0;
    int ecnt = 0, cap = 0, gcnt = 0, bcnt = 0, busy_rise = 0, press = 0;
    logic last_db = 1'b0, last_busy = 1'b0;
    logic m_sync1 = 1'b0, m_s = 1'b0, lvl = 1'b0, m_gl = 1'b0;
    int run = 0;
    logic [2:0] sb[$];

    button_debouncer #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
        .clk(clk), .n_rst(n_rst), .btn_raw(btn_raw),
        .db_out(db_out), .busy(busy), .glitch(glitch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference: counts consecutive synchronised samples disagreeing with the accepted level
    task automatic cycle();
        logic [2:0] o, e;
        @(posedge clk);
        ecnt++;
        if (!n_rst) begin
            m_sync1 = 1'b0; m_s = 1'b0; lvl = 1'b0; run = 0; m_gl = 1'b0;
        end else begin
            m_gl = 1'b0;
            if (m_s != lvl) begin
                run++;
                if (run == D + 1) begin
                    lvl = m_s;
                    run = 0;
                end
            end else begin
                m_gl = (run != 0);
                run  = 0;
            end
            m_s     = m_sync1;
            m_sync1 = btn_raw;
        end
        sb.push_back({lvl, run != 0, m_gl});
        @(negedge clk);
        o = {db_out, busy, glitch};
        e = sb.pop_front();
        if (busy === 1'b1 && last_busy !== 1'b1) busy_rise = ecnt;
        if (glitch === 1'b1) gcnt++;
        if (busy === 1'b1) bcnt++;
        last_db   = db_out;
        last_busy = busy;
        chk("cycle_outputs", o, e);
    endtask

    task automatic drive(input logic v);
        btn_raw = v;
        cap = ecnt + 1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_db(input logic tgt);
        int n = 0;
        while (last_db !== tgt && n < 60) begin
            cycle();
            n++;
        end
        if (n >= 60) chk("wait_db_timeout", 32'(last_db), 32'(tgt));
    endtask

    initial begin
        n_rst   = 1'b0;
        btn_raw = 1'b0;
        #1 chk("reset_outputs", {29'd0, db_out, busy, glitch}, 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        cycles(4);

        // clean press and clean release
        gcnt = 0; bcnt = 0;
        drive(1'b1);
        cycles(30);
        chk("press_busy_start", busy_rise - cap, 2);
        chk("press_busy_len", bcnt, D);
        chk("press_no_glitch", gcnt, 0);
        chk("press_db", 32'(last_db), 1);
        drive(1'b0);
        wait_db(1'b0);
        chk("release_latency", ecnt - cap, D + 2);
        cycles(12);

        // bounce burst: four 3-cycle highs, each rejected
        gcnt = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1); cycles(3);
            drive(1'b0); cycles(3);
        end
        cycles(12);
        chk("burst_glitches", gcnt, 4);
        chk("burst_db", 32'(last_db), 0);
        chk("burst_busy", 32'(last_busy), 0);

        // threshold: D-cycle pulse rejected, D+1-cycle pulse accepted
        gcnt = 0;
        drive(1'b1); cycles(D);
        drive(1'b0); cycles(14);
        chk("thr8_glitch", gcnt, 1);
        chk("thr8_db", 32'(last_db), 0);
        gcnt = 0;
        drive(1'b1); press = cap; cycles(D + 1);
        drive(1'b0);
        wait_db(1'b1);
        chk("thr9_rise", ecnt - press, D + 2);
        wait_db(1'b0);
        chk("thr9_fall", ecnt - cap, D + 2);
        chk("thr9_no_glitch", gcnt, 0);
        cycles(6);

        // release with bounce from a settled high level
        drive(1'b1); cycles(16);
        chk("pre_release_db", 32'(last_db), 1);
        gcnt = 0;
        drive(1'b0); cycles(2);
        drive(1'b1); cycles(2);
        drive(1'b0); cycles(2);
        drive(1'b1); cycles(2);
        drive(1'b0);
        wait_db(1'b0);
        chk("bounce_release_latency", ecnt - cap, D + 2);
        chk("bounce_release_glitches", gcnt, 2);
        cycles(6);

        // reset asserted four cycles into the high wait
        drive(1'b1);
        cycles(7);
        chk("pre_reset_busy", 32'(last_busy), 1);
        gcnt = 0;
        #2 n_rst = 1'b0;
        #1 chk("async_reset_outputs", {29'd0, db_out, busy, glitch}, 32'd0);
        cycles(2);
        @(negedge clk);
        #1 n_rst = 1'b1;
        cap = ecnt + 1;
        wait_db(1'b1);
        chk("post_reset_latency", ecnt - cap, D + 2);
        chk("reset_no_glitch", gcnt, 0);
        cycles(4);

        // off-edge toggles with assorted hold lengths
        begin
            int lens[8] = '{2, 11, 5, 9, 1, 12, 8, 14};
            for (int i = 0; i < 8; i++) begin
                #($urandom_range(1, 3));
                btn_raw = ~btn_raw;
                cycles(lens[i]);
            end
        end
        cycles(14);
        chk("offedge_final_db", 32'(last_db), 32'(btn_raw));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
